// File: rtl/eh2_pkg.sv
// Shared types for the eh2 atomic responder: funct5 op codes, FSM states and the
// LR reservation record.
package eh2_pkg;

  typedef enum logic [4:0] {
    AMO_ADD  = 5'd0,
    AMO_SWAP = 5'd1,
    AMO_LR   = 5'd2,
    AMO_SC   = 5'd3,
    AMO_XOR  = 5'd4,
    AMO_OR   = 5'd8,
    AMO_AND  = 5'd12,
    AMO_MIN  = 5'd16,
    AMO_MAX  = 5'd20,
    AMO_MINU = 5'd24,
    AMO_MAXU = 5'd28
  } eh2_amo_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CALC = 3'd2,
    ST_WR   = 3'd3,
    ST_RSP  = 3'd4
  } eh2_amo_state_e;

  // Word addresses are stored at the widest possible width and compared zero-extended.
  localparam int unsigned EH2_RESV_AW = 30;

  typedef struct packed {
    logic                   valid;
    logic [EH2_RESV_AW-1:0] waddr;
  } eh2_amo_resv_t;

  function automatic logic amo_op_supported(input logic [4:0] op);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd12,
      5'd16, 5'd20, 5'd24, 5'd28: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/eh2_amo_responder_alu.sv
// Combinational AMO update: new = f(op, old, data). Min/max use a 33-bit subtract;
// the signed forms flip both sign bits first. Ties keep the old word.
module eh2_amo_responder_alu
  import eh2_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] old,
  input  logic [31:0] data,
  output logic [31:0] result
);

  logic [32:0] diff_u;
  logic [32:0] diff_s;
  logic        lt_u;
  logic        lt_s;
  logic        eq;

  // Compare old against data, then select the updated word.
  always_comb begin
    diff_u = {1'b0, old} - {1'b0, data};
    diff_s = {1'b0, old ^ 32'h8000_0000} - {1'b0, data ^ 32'h8000_0000};
    lt_u   = diff_u[32];
    lt_s   = diff_s[32];
    eq     = (diff_u[31:0] == 32'd0);
    case (op)
      AMO_ADD:          result = old + data;
      AMO_SWAP, AMO_SC: result = data;
      AMO_XOR:          result = old ^ data;
      AMO_OR:           result = old | data;
      AMO_AND:          result = old & data;
      AMO_MIN:          result = (lt_s | eq) ? old : data;
      AMO_MAX:          result = lt_s ? data : old;
      AMO_MINU:         result = (lt_u | eq) ? old : data;
      AMO_MAXU:         result = lt_u ? data : old;
      default:          result = old;
    endcase
  end

endmodule

// File: rtl/eh2_amo_responder.sv
// Memory-side RISC-V atomic responder (AMO/LR/SC) in front of a 1-cycle word SRAM.
// Define RV_AMO_RESERVATION_EN to build the per-thread LR reservation slots.
module eh2_amo_responder
  import eh2_pkg::*;
#(
  parameter int MEM_AW      = 14,
  parameter int NUM_THREADS = 2,
  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [4:0]        req_op,
  input  logic [31:0]       req_data,
  input  logic [TW-1:0]     req_tid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic [TW-1:0]     rsp_tid,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              ext_wr_valid,
  input  logic [31:0]       ext_wr_addr
);

  eh2_amo_state_e    state;
  logic [MEM_AW-1:0] lat_waddr;
  logic [4:0]        lat_op;
  logic [31:0]       lat_data;
  logic [TW-1:0]     lat_tid;
  logic [31:0]       new_val;
  logic [31:0]       rsp_val;
  logic              rsp_er;

  logic              accept;
  logic              req_err;
  logic              sc_ok;
  logic [MEM_AW-1:0] req_waddr;
  logic [31:0]       alu_result;

  assign req_ready = (state == ST_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign req_waddr = req_addr[MEM_AW+1:2];
  assign req_err   = (req_addr[1:0] != 2'b00) | ~amo_op_supported(req_op);

  eh2_amo_responder_alu u_alu (
    .op     (lat_op),
    .old    (mem_rdata),
    .data   (lat_data),
    .result (alu_result)
  );

  // Request FSM; the response word is prepared on the way so RSP only holds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_waddr <= '0;
      lat_op    <= 5'd0;
      lat_data  <= 32'd0;
      lat_tid   <= '0;
      new_val   <= 32'd0;
      rsp_val   <= 32'd0;
      rsp_er    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_waddr <= req_waddr;
            lat_op    <= req_op;
            lat_data  <= req_data;
            lat_tid   <= req_tid;
            if (req_err) begin
              rsp_val <= 32'd0;
              rsp_er  <= 1'b1;
              state   <= ST_RSP;
            end else if (req_op == AMO_SC) begin
              rsp_er <= 1'b0;
              if (sc_ok) begin
                rsp_val <= 32'd0;
                new_val <= req_data;
                state   <= ST_WR;
              end else begin
                rsp_val <= 32'd1;
                state   <= ST_RSP;
              end
            end else begin
              rsp_er <= 1'b0;
              state  <= ST_RD;
            end
          end
        end
        ST_RD:   state <= ST_CALC;
        ST_CALC: begin
          rsp_val <= mem_rdata;
          new_val <= alu_result;
          state   <= (lat_op == AMO_LR) ? ST_RSP : ST_WR;
        end
        ST_WR:   state <= ST_RSP;
        ST_RSP:  if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Idle outputs read as zero; rst kills the strobe so an aborted WR writes nothing.
  assign mem_en    = ~rst & ((state == ST_RD) | (state == ST_WR));
  assign mem_wen   = ~rst & (state == ST_WR);
  assign mem_addr  = mem_en ? lat_waddr : '0;
  assign mem_wdata = mem_wen ? new_val : 32'd0;
  assign rsp_valid = ~rst & (state == ST_RSP);
  assign rsp_data  = rsp_valid ? rsp_val : 32'd0;
  assign rsp_err   = rsp_valid & rsp_er;
  assign rsp_tid   = rsp_valid ? lat_tid : '0;

`ifdef RV_AMO_RESERVATION_EN
  eh2_amo_resv_t resv [NUM_THREADS];
  logic          unused_bits;

  assign sc_ok = resv[req_tid].valid &
                 (resv[req_tid].waddr == EH2_RESV_AW'(req_waddr));
  assign unused_bits = ^{req_addr[31:MEM_AW+2], ext_wr_addr[31:MEM_AW+2], ext_wr_addr[1:0]};

  // Clears (external write, own write, any SC) first; a same-cycle LR set overrides.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++) resv[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if ((ext_wr_valid & (resv[i].waddr == EH2_RESV_AW'(ext_wr_addr[MEM_AW+1:2]))) |
            (mem_wen & (resv[i].waddr == EH2_RESV_AW'(lat_waddr))) |
            (accept & (req_op == AMO_SC) & (req_tid == TW'(i)))) begin
          resv[i].valid <= 1'b0;
        end
        if ((state == ST_CALC) & (lat_op == AMO_LR) & (lat_tid == TW'(i))) begin
          resv[i] <= '{valid: 1'b1, waddr: EH2_RESV_AW'(lat_waddr)};
        end
      end
    end
  end
`else
  logic unused_bits;

  assign sc_ok       = 1'b0;
  assign unused_bits = ^{req_addr[31:MEM_AW+2], ext_wr_valid, ext_wr_addr};
`endif

endmodule

// File: tb/tb_eh2_amo_responder.sv
// Scoreboard bench for eh2_amo_responder: directed and random AMO/LR/SC traffic checked
// against a behavioural model of memory and reservations.
`timescale 1ns/1ps
module tb_eh2_amo_responder;

  localparam int MEM_AW = 14;
  localparam int NT     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_addr = 32'd0;
  logic [4:0]        req_op = 5'd0;
  logic [31:0]       req_data = 32'd0;
  logic [0:0]        req_tid = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic [0:0]        rsp_tid;
  logic              mem_en;
  logic              mem_wen;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'd0;
  logic              ext_wr_valid = 1'b0;
  logic [31:0]       ext_wr_addr = 32'd0;

  always #5 clk = ~clk;

  eh2_amo_responder #(.MEM_AW(MEM_AW), .NUM_THREADS(NT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_data(req_data), .req_tid(req_tid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_tid(rsp_tid),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ext_wr_valid(ext_wr_valid), .ext_wr_addr(ext_wr_addr)
  );

  // SRAM with a backdoor preload port
  logic [31:0] sram [0:15];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_a = 4'd0;
  logic [31:0] bd_d = 32'd0;
  always @(posedge clk) begin
    if (bd_we) sram[bd_a] <= bd_d;
    else if (mem_en && mem_wen) sram[mem_addr[3:0]] <= mem_wdata;
    if (mem_en && !mem_wen) mem_rdata <= sram[mem_addr[3:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [0:0]  tid;
    int          lat;
    int          nstrb;
    int          acc;
  } exp_t;
  typedef struct {
    logic [MEM_AW-1:0] a;
    logic [31:0]       d;
  } wr_t;
  exp_t rq[$];
  wr_t  wq[$];

  // Reference model state
  logic [31:0] ref_mem [16];
  bit          rv [NT];
  int          ra [NT];

  function automatic logic [31:0] amo_f(input int op, input logic [31:0] o, input logic [31:0] d);
    case (op)
      0:       return o + d;
      1:       return d;
      4:       return o ^ d;
      8:       return o | d;
      12:      return o & d;
      16:      return ($signed(o) <= $signed(d)) ? o : d;
      20:      return ($signed(o) >= $signed(d)) ? o : d;
      24:      return (o <= d) ? o : d;
      28:      return (o >= d) ? o : d;
      default: return o;
    endcase
  endfunction

  function automatic void clear_match(input int w);
    for (int i = 0; i < NT; i++) if (ra[i] == w) rv[i] = 1'b0;
  endfunction

  task automatic preload(input int w, input logic [31:0] v);
    @(negedge clk);
    bd_we = 1'b1; bd_a = 4'(w); bd_d = v;
    ref_mem[w] = v;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: req_ready stuck at %b", req_ready);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data, input int tid);
    exp_t e;
    int   w;
    bit   err;
    bit   ok;
    logic [31:0] nv;
    w   = int'(addr[5:2]);
    err = (addr[1:0] != 2'b00) || !(op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8,
                                               5'd12, 5'd16, 5'd20, 5'd24, 5'd28});
    e.tid = 1'(tid);
    e.err = 1'b0;
    ok    = 1'b0;
    if (err) begin
      e.data = 32'd0; e.err = 1'b1; e.lat = 1; e.nstrb = 0;
`ifdef RV_AMO_RESERVATION_EN
      if (op == 5'd3) rv[tid] = 1'b0;
`endif
    end else if (op == 5'd2) begin
      e.data = ref_mem[w]; e.lat = 3; e.nstrb = 1;
`ifdef RV_AMO_RESERVATION_EN
      rv[tid] = 1'b1; ra[tid] = w;
`endif
    end else if (op == 5'd3) begin
`ifdef RV_AMO_RESERVATION_EN
      ok = rv[tid] && (ra[tid] == w);
      rv[tid] = 1'b0;
`endif
      if (ok) begin
        e.data = 32'd0; e.lat = 2; e.nstrb = 1;
        wq.push_back('{a: MEM_AW'(w), d: data});
        ref_mem[w] = data;
        clear_match(w);
      end else begin
        e.data = 32'd1; e.lat = 1; e.nstrb = 0;
      end
    end else begin
      nv = amo_f(int'(op), ref_mem[w], data);
      e.data = ref_mem[w]; e.lat = 4; e.nstrb = 2;
      wq.push_back('{a: MEM_AW'(w), d: nv});
      ref_mem[w] = nv;
      clear_match(w);
    end
    wait_idle();
    req_valid = 1'b1; req_addr = addr; req_op = op; req_data = data; req_tid = 1'(tid);
    e.acc = cyc;
    rq.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic ext_pulse(input logic [31:0] a);
    wait_idle();
    ext_wr_valid = 1'b1; ext_wr_addr = a;
    @(negedge clk);
    ext_wr_valid = 1'b0;
`ifdef RV_AMO_RESERVATION_EN
    clear_match(int'(a[5:2]));
`endif
  endtask

  // Monitor: checks writes and responses against the queues, randomises rsp_ready back-pressure
  int strobes = 0;
  bit seen = 1'b0;
  int hold = 0;
  int next_hold = -1;
  bit mon_en = 1'b1;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (mem_en) begin
        strobes++;
        if (mem_wen) begin
          if (wq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_write: addr %h data %h", mem_addr, mem_wdata);
          end else begin
            chk("wr_addr", 32'(mem_addr), 32'(wq[0].a));
            chk("wr_data", mem_wdata, wq[0].d);
            void'(wq.pop_front());
          end
        end
      end
      if (rsp_valid) begin
        if (rq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_rsp: data %h err %b", rsp_data, rsp_err);
          rsp_ready = 1'b1;
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", 32'(cyc - rq[0].acc), 32'(rq[0].lat));
            chk("mem_strobes", 32'(strobes), 32'(rq[0].nstrb));
            hold = (next_hold >= 0) ? next_hold : int'($urandom_range(0, 2));
            next_hold = -1;
          end
          chk("rsp_data", rsp_data, rq[0].data);
          chk("rsp_err", 32'(rsp_err), 32'(rq[0].err));
          chk("rsp_tid", 32'(rsp_tid), 32'(rq[0].tid));
          chk("req_ready_busy", 32'(req_ready), 32'd0);
          if (hold == 0) begin
            rsp_ready = 1'b1;
            void'(rq.pop_front());
            seen = 1'b0;
            strobes = 0;
          end else begin
            hold--;
            rsp_ready = 1'b0;
          end
        end
      end else begin
        rsp_ready = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0]  ops [12];
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    int          w;
    int          n;
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24, 5'd28, 5'd2};
    for (int i = 0; i < NT; i++) begin rv[i] = 1'b0; ra[i] = -1; end

    for (int i = 0; i < 16; i++) preload(i, $urandom());
    preload(4, 32'h7FFF_FFFF);
    preload(5, 32'hFFFF_FFFF);
    preload(6, 32'hFFFF_FFFF);
    preload(7, 32'h1234_5678);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err_tid", {30'd0, rsp_err, rsp_tid}, 32'd0);
    chk("rst_mem_en_wen", {30'd0, mem_en, mem_wen}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Directed
    next_hold = 3;
    issue(5'd0,  32'h10, 32'd1, 0);
    issue(5'd20, 32'h14, 32'd1, 1);
    issue(5'd28, 32'h18, 32'd1, 0);
    issue(5'd16, 32'h1C, 32'h1234_5678, 1);
    issue(5'd2,  32'h20, 32'd0, 0);
    issue(5'd3,  32'h20, 32'hCAFE_0001, 0);
    issue(5'd3,  32'h20, 32'hCAFE_0002, 0);
    issue(5'd2,  32'h20, 32'd0, 0);
    issue(5'd1,  32'h20, 32'h5555_AAAA, 1);
    issue(5'd3,  32'h20, 32'hCAFE_0003, 0);
    issue(5'd2,  32'h20, 32'd0, 0);
    ext_pulse(32'h23);
    issue(5'd3,  32'h20, 32'hCAFE_0004, 0);
    issue(5'd2,  32'h24, 32'd0, 1);
    issue(5'd3,  32'h24, 32'hBEEF_0001, 1);
    issue(5'd0,  32'h22, 32'd7, 0);
    issue(5'd5,  32'h10, 32'd7, 1);

    // Random
    for (int k = 0; k < 300; k++) begin
      w  = int'($urandom_range(0, 15));
      op = ($urandom_range(0, 15) == 0) ? 5'(($urandom_range(0, 7) * 4) + 5) : ops[$urandom_range(0, 11)];
      a  = 32'(w * 4);
      if ($urandom_range(0, 12) == 0) a = a | 32'($urandom_range(1, 3));
      d  = ($urandom_range(0, 3) == 0) ? ref_mem[w] : $urandom();
      issue(op, a, d, int'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) ext_pulse(32'($urandom_range(0, 63)));
    end

    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_rsp_queue", 32'(rq.size()), 32'd0);
    chk("drain_wr_queue", 32'(wq.size()), 32'd0);

    // Reset during WR: no write, no response, IDLE afterwards
    mon_en = 1'b0;
    wait_idle();
    req_valid = 1'b1; req_addr = 32'h0C; req_op = 5'd0; req_data = 32'h0000_0100; req_tid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!mem_wen && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr", 32'(mem_wen), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_gates_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("abort_no_write", sram[3], ref_mem[3]);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_next", 32'(req_ready), 32'd1);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
